// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment counter sequencer.
package ssd_pkg;

  localparam int SSD_W         = 4;
  localparam int MAX_STATE_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } ssd_fsm_e;

  // Prescaler counter width; never below one bit so TICK_DIV=1 still builds.
  function automatic int clog2(input int unsigned v);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(v)) w++;
    return w;
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Prescaler: counts enabled cycles and pulses tick_o on the last count of each period.
module ssd_tick_gen
  import ssd_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ssd_seq_ctrl.sv
// Run/pause/step/clear sequencer producing the 0..MAX_STATE digit value and a wrap count.
module ssd_seq_ctrl
  import ssd_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int MAX_STATE = MAX_STATE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic             clear,
  input  logic             wrap_en,
  output logic [SSD_W-1:0] state,
  output logic [SSD_W-1:0] wraps,
  output logic             tick,
  output logic             running,
  output logic             done
);

  localparam logic [SSD_W-1:0] MAX_ST = SSD_W'(MAX_STATE);

  ssd_fsm_e         fsm_q;
  logic [SSD_W-1:0] state_q, wraps_q;
  logic             done_q;
  logic             start_q, pause_q, step_q, clear_q;
  logic             start_c, pause_c, step_c, clear_c;
  logic             tick_w, presc_en, presc_clr;
  logic             adv_go, adv_done;
  logic [SSD_W-1:0] adv_state, adv_wraps;

  assign start_c = start & ~start_q;
  assign pause_c = pause & ~pause_q;
  assign step_c  = step  & ~step_q;
  assign clear_c = clear & ~clear_q;

  // Resuming from PAUSE keeps the partial count; fresh runs start from zero.
  assign presc_en  = (fsm_q == RUN);
  assign presc_clr = clear_c || (start_c && (fsm_q == IDLE || fsm_q == DONE));

  ssd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (presc_en),
    .clr_i  (presc_clr),
    .tick_o (tick_w)
  );

  always_comb begin
    adv_state = state_q;
    adv_wraps = wraps_q;
    adv_done  = 1'b0;
    if (state_q < MAX_ST) begin
      adv_state = state_q + 1'b1;
    end else if (wrap_en) begin
      adv_state = '0;
      adv_wraps = wraps_q + 1'b1;
    end else begin
      adv_done  = 1'b1;
    end
  end

  always_comb begin
    adv_go = 1'b0;
    if (!clear_c) begin
      case (fsm_q)
        IDLE, PAUSE: adv_go = step_c && !start_c;
        RUN:         adv_go = tick_w;
        default:     adv_go = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      wraps_q <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      step_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      start_q <= start;
      pause_q <= pause;
      step_q  <= step;
      clear_q <= clear;
      done_q  <= 1'b0;
      if (clear_c) begin
        fsm_q   <= IDLE;
        state_q <= '0;
        wraps_q <= '0;
      end else begin
        case (fsm_q)
          IDLE, PAUSE: if (start_c) fsm_q <= RUN;
          RUN:         if (pause_c) fsm_q <= PAUSE;
          DONE: if (start_c) begin
            fsm_q   <= RUN;
            state_q <= '0;
          end
          default: fsm_q <= IDLE;
        endcase
        // Placed last so reaching the end without wrap overrides a same-cycle pause.
        if (adv_go) begin
          state_q <= adv_state;
          wraps_q <= adv_wraps;
          if (adv_done) begin
            fsm_q  <= DONE;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign state   = state_q;
  assign wraps   = wraps_q;
  assign tick    = tick_w;
  assign running = (fsm_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_ssd_seq_ctrl.sv
// Directed bench for ssd_seq_ctrl: TICK_DIV=4 main instance plus a TICK_DIV=1 instance.
module tb_ssd_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, pause, step, clear, wrap_en;
  logic [3:0] state, wraps;
  logic       tick, running, done;

  logic       start1, pause1, step1, clear1, wrap_en1;
  logic [3:0] state1, wraps1;
  logic       tick1, running1, done1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ssd_seq_ctrl #(.TICK_DIV(4), .MAX_STATE(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .step(step),
    .clear(clear), .wrap_en(wrap_en), .state(state), .wraps(wraps),
    .tick(tick), .running(running), .done(done)
  );

  ssd_seq_ctrl #(.TICK_DIV(1), .MAX_STATE(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pause(pause1), .step(step1),
    .clear(clear1), .wrap_en(wrap_en1), .state(state1), .wraps(wraps1),
    .tick(tick1), .running(running1), .done(done1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_pulse();
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
  endtask

  logic bad;

  initial begin
    rst_n = 1'b0;
    {start, pause, step, clear, wrap_en} = '0;
    {start1, pause1, step1, clear1, wrap_en1} = '0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_wraps", wraps, 0);
    chk("rst_tick", tick, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_tick_div1", tick1, 0);
    #10 rst_n = 1'b1;
    cyc();

    // Run to DONE without wrap
    start = 1'b1; cyc(); start = 1'b0;
    chk("run_running", running, 1);
    chk("run_tick0", tick, 0);
    for (int k = 1; k <= 10; k++) begin
      repeat (3) cyc();
      chk($sformatf("tick%0d", k), tick, 1);
      chk($sformatf("tick%0d_state", k), state, k - 1);
      cyc();
      chk($sformatf("adv%0d_state", k), state, k);
      chk($sformatf("adv%0d_tick", k), tick, 0);
    end
    repeat (3) cyc();
    chk("tick11", tick, 1);
    cyc();
    chk("done_pulse", done, 1);
    chk("done_running", running, 0);
    chk("done_state", state, 10);
    cyc();
    chk("done_once", done, 0);
    chk("done_hold_state", state, 10);

    // Wrap mode restarted from DONE
    wrap_en = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_state", state, 0);
    chk("restart_running", running, 1);
    repeat (44) cyc();
    chk("wrap1_state", state, 0);
    chk("wrap1_wraps", wraps, 1);
    repeat (616) cyc();
    chk("wrap15_wraps", wraps, 15);
    repeat (44) cyc();
    chk("wrap16_wraps", wraps, 0);
    chk("wrap16_state", state, 0);
    repeat (44) cyc();
    repeat (4) cyc();
    chk("pre_clear_wraps", wraps, 1);
    chk("pre_clear_state", state, 1);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear_state", state, 0);
    chk("clear_wraps", wraps, 0);
    chk("clear_running", running, 0);

    // Pause and resume keeps the partial prescale
    wrap_en = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    chk("pr_state1", state, 1);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("pause_running", running, 0);
    bad = 1'b0;
    repeat (20) begin
      cyc();
      if (tick !== 1'b0 || state !== 4'd1) bad = 1'b1;
    end
    chk("pause_frozen", bad, 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("resume_running", running, 1);
    chk("resume_tick_r0", tick, 0);
    cyc();
    chk("resume_tick_r1", tick, 0);
    cyc();
    chk("resume_tick_r2", tick, 1);
    cyc();
    chk("resume_state", state, 2);

    // Pause in the tick cycle: advance applies and FSM pauses
    repeat (3) cyc();
    chk("pt_tick", tick, 1);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("pt_state", state, 3);
    chk("pt_running", running, 0);

    // Clear and start together in RUN at state 7
    start = 1'b1; cyc(); start = 1'b0;
    repeat (16) cyc();
    chk("cs_state7", state, 7);
    clear = 1'b1; start = 1'b1; cyc(); clear = 1'b0; start = 1'b0;
    chk("cs_state", state, 0);
    chk("cs_wraps", wraps, 0);
    chk("cs_running", running, 0);

    // Single-step from IDLE
    repeat (3) step_pulse();
    chk("step3_state", state, 3);
    chk("step3_running", running, 0);
    step = 1'b1;
    repeat (10) cyc();
    step = 1'b0; cyc();
    chk("step_held_state", state, 4);
    repeat (6) step_pulse();
    chk("step10_state", state, 10);
    chk("step10_done", done, 0);
    step = 1'b1; cyc(); step = 1'b0;
    chk("step_done_pulse", done, 1);
    chk("step_done_state", state, 10);
    cyc();
    chk("step_done_once", done, 0);
    step_pulse();
    chk("step_in_done_ignored", state, 10);

    // Async reset in the middle of a pending tick
    start = 1'b1; cyc(); start = 1'b0;
    repeat (7) cyc();
    chk("ar_pre_tick", tick, 1);
    chk("ar_pre_state", state, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_tick", tick, 0);
    chk("ar_running", running, 0);
    chk("ar_done", done, 0);
    #3 rst_n = 1'b1;
    cyc();
    chk("ar_after_running", running, 0);
    chk("ar_after_state", state, 0);

    // TICK_DIV=1 ticks every RUN cycle
    start1 = 1'b1; cyc(); start1 = 1'b0;
    chk("d1_tick", tick1, 1);
    chk("d1_state0", state1, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("d1_state%0d", k), state1, k);
    end
    chk("d1_running", running1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
